// File: rtl/aplic_msi_if.sv
// MSI write channel between the APLIC MSI scheduler (master) and the bus master (slave).
// Address/data travel on one valid/ready beat; bvalid returns the write response.
interface aplic_msi_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              bvalid;

  modport master (output valid, addr, data, input ready, bvalid);
  modport slave  (input valid, addr, data, output ready, bvalid);
endinterface

// File: rtl/aplic_msi_scheduler.sv
// MSI delivery sequencer for an APLIC domain in MSI mode: picks a pending source
// round-robin, fetches its target register, and issues one MSI write at a time.
module aplic_msi_scheduler #(
  parameter int unsigned NR_SRC = 32,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_domain_ie,
  input  logic [NR_SRC-1:0]           i_pending,
  input  logic [NR_SRC-1:0]           i_enabled,
  input  logic [ADDR_W-13:0]          i_msi_base_ppn,
  output logic [$clog2(NR_SRC)-1:0]   o_cfg_idx,
  input  logic [31:0]                 i_cfg_target,
  output logic [NR_SRC-1:0]           o_clr_pending,
  aplic_msi_if.master                 msi,
  output logic                        o_busy
);

  localparam int unsigned IDX_W  = $clog2(NR_SRC);
  localparam int unsigned PPN_W  = ADDR_W - 12;
  localparam int unsigned HART_W = 14;
  localparam int unsigned EIID_W = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT_B
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    last_served;
  logic [NR_SRC-1:0]   eligible;
  logic [NR_SRC-1:0]   sel_onehot;
  logic [IDX_W-1:0]    rr_idx;
  logic [IDX_W-1:0]    lo_idx;
  logic [IDX_W-1:0]    hi_idx;
  logic                hi_found;
  logic [HART_W-1:0]   tgt_hart;
  logic [EIID_W-1:0]   tgt_eiid;
  logic                sel_still_eligible;
  logic                unused_tgt;

  assign tgt_hart           = i_cfg_target[31:18];
  assign tgt_eiid           = i_cfg_target[10:0];
  assign unused_tgt         = ^i_cfg_target[17:11];
  assign sel_onehot         = NR_SRC'(1) << sel_idx;
  assign sel_still_eligible = eligible[sel_idx];
  assign o_cfg_idx          = sel_idx;
  assign o_busy             = (state != S_IDLE);

  // Source 0 is reserved and never eligible.
  always_comb begin
    eligible    = i_pending & i_enabled;
    eligible[0] = 1'b0;
  end

  // Round-robin pick: lowest eligible above last_served, else lowest overall.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = int'(NR_SRC) - 1; i >= 1; i--) begin
      if (eligible[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) > last_served) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  // Clear pulse lands in the same cycle as the accepting handshake or the EIID==0 drop.
  always_comb begin
    o_clr_pending = '0;
    if (!i_rst) begin
      if (state == S_ISSUE && msi.valid && msi.ready) begin
        o_clr_pending = sel_onehot;
      end else if (state == S_CAPTURE && sel_still_eligible && tgt_eiid == '0) begin
        o_clr_pending = sel_onehot;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      sel_idx     <= '0;
      last_served <= '0;
      msi.valid   <= 1'b0;
      msi.addr    <= '0;
      msi.data    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_domain_ie && (|eligible)) begin
            sel_idx <= rr_idx;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!sel_still_eligible) begin
            state <= S_IDLE;
          end else if (tgt_eiid == '0) begin
            last_served <= sel_idx;
            state       <= S_IDLE;
          end else begin
            msi.addr  <= {i_msi_base_ppn + PPN_W'(tgt_hart), 12'h000};
            msi.data  <= {21'b0, tgt_eiid};
            msi.valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (msi.ready) begin
            msi.valid   <= 1'b0;
            last_served <= sel_idx;
            state       <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (msi.bvalid) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
